// File: rtl/regfile_pkg.sv
// Shared types and sizes for the architectural register file and its buffered write port.
package regfile_pkg;

  localparam int unsigned REG_W  = 64;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam logic [ADDR_W-1:0] XZR = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } regfile_wr_t;

  typedef logic [NREGS-1:0][REG_W-1:0] reg_array_t;

endpackage

// File: rtl/regfile_write_store_wr_fifo.sv
// In-order write buffer; exposes every slot plus a valid mask so the top can run hazard compares.
module wr_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  regfile_wr_t                   din,
  input  logic                          pop,
  output regfile_wr_t                   head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output regfile_wr_t [DEPTH-1:0]       entries,
  output logic [DEPTH-1:0]              valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]        head_ptr;
  logic [PTR_W-1:0]        tail_ptr;
  regfile_wr_t [DEPTH-1:0] mem;
  logic                    push_ok;
  logic                    pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop_ok)  head_ptr <= head_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[tail_ptr] <= din;
  end

  assign head    = mem[head_ptr];
  assign entries = mem;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == CNT_W'(0));

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] offs;
    offs  = '0;
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs     = PTR_W'(i) - head_ptr;
      valid[i] = ({1'b0, offs} < count);
    end
  end

endmodule

// File: rtl/regfile_write_store.sv
// 32 x 64-bit register storage fed by a buffered, in-order write port with a pending-write hazard check.
module regfile_write_store
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [REG_W-1:0]       wr_data,
  input  logic                   commit_en,
  input  logic [ADDR_W-1:0]      chk_addr,
  output logic                   chk_hit,
  output logic [$clog2(DEPTH):0] count,
  output reg_array_t             regs
);

  logic [NREGS-2:0][REG_W-1:0] arr;
  regfile_wr_t                 wr_entry;
  regfile_wr_t                 head;
  regfile_wr_t [DEPTH-1:0]     entries;
  logic [DEPTH-1:0]            valid;
  logic                        full;
  logic                        empty;
  logic                        push;
  logic                        pop;

  assign wr_entry = '{addr: wr_addr, data: wr_data};
  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;
  assign pop      = commit_en && !empty;

  wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .din     (wr_entry),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .entries (entries),
    .valid   (valid)
  );

  // XZR has no storage; a popped write to it just drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      arr <= '0;
    end else if (pop && (head.addr != XZR)) begin
      arr[head.addr] <= head.data;
    end
  end

  always_comb begin
    regs          = '0;
    regs[NREGS-2:0] = arr;
  end

  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr == chk_addr)) hit = 1'b1;
    end
    chk_hit = hit && (chk_addr != XZR);
  end

endmodule
